// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared constants for the SPI transfer sequencer: default sizes, FSM state
// encodings and the wait/lead/tail counter width helper.
package spi_xfer_pkg;

  localparam int DEF_DWIDTH  = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_SS_LEAD = 2;
  localparam int DEF_SS_TAIL = 2;
  localparam int DEF_TIMEOUT = 255;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEAD    = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;
  localparam logic [2:0] S_TAIL    = 3'd6;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Host FIFO handshake plus spi_core strobe bundle; slave = sequencer, master = host/core side.
// With SPI_XFER_RX_OVF_EN defined the bundle also carries the sticky rx_ovf flag.
interface spi_xfer_ctrl_if
  import spi_xfer_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) ();
  logic [DWIDTH-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DWIDTH-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              core_cs;
  logic              core_wr;
  logic              core_rd;
  logic [DWIDTH-1:0] core_din;
  logic [DWIDTH-1:0] core_dout;
  logic              core_done;
  logic              ss_n;
  logic              busy;
  logic              err;
`ifdef SPI_XFER_RX_OVF_EN
  logic              rx_ovf;

  modport slave (
    input  tx_data, tx_valid, rx_ready, core_dout, core_done,
    output tx_ready, rx_data, rx_valid, core_cs, core_wr, core_rd, core_din,
           ss_n, busy, err, rx_ovf
  );
  modport master (
    output tx_data, tx_valid, rx_ready, core_dout, core_done,
    input  tx_ready, rx_data, rx_valid, core_cs, core_wr, core_rd, core_din,
           ss_n, busy, err, rx_ovf
  );
`else
  modport slave (
    input  tx_data, tx_valid, rx_ready, core_dout, core_done,
    output tx_ready, rx_data, rx_valid, core_cs, core_wr, core_rd, core_din,
           ss_n, busy, err
  );
  modport master (
    output tx_data, tx_valid, rx_ready, core_dout, core_done,
    input  tx_ready, rx_data, rx_valid, core_cs, core_wr, core_rd, core_din,
           ss_n, busy, err
  );
`endif
endinterface

// File: rtl/spi_xfer_ctrl_sync_fifo.sv
// Single-clock FIFO, power-of-2 depth. A push is accepted on a full FIFO when
// the head is popped in the same cycle; an empty FIFO never bypasses.
module sync_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DWIDTH-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);
  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       cnt_q;
  logic              push;
  logic              pop;

  assign out_valid_o = (cnt_q != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign in_ready_o  = (cnt_q != (AW+1)'(DEPTH)) || pop;
  assign push        = in_valid_i && in_ready_o;
  assign out_data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end
endmodule

// File: rtl/spi_xfer_ctrl.sv
// Sequences host words through spi_core and owns ss_n across back-to-back words.
// SPI_XFER_RX_OVF_EN: drop words on RX full (sticky rx_ovf) instead of stalling.
module spi_xfer_ctrl
  import spi_xfer_pkg::*;
#(
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int SS_LEAD = DEF_SS_LEAD,
  parameter int SS_TAIL = DEF_SS_TAIL,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic            clk,
  input logic            rst,
  spi_xfer_ctrl_if.slave bus
);
  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LEAD_LD = CW'(SS_LEAD - 1);
  localparam logic [CW-1:0] TAIL_LD = CW'(SS_TAIL - 1);
  localparam logic [CW-1:0] TMO_LD  = CW'(TIMEOUT - 1);

`ifdef SPI_XFER_RX_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ss_n_q, ss_n_d;
  logic              wr_q, wr_d;
  logic [DWIDTH-1:0] din_q, din_d;
  logic              err_q, err_d;
  logic [DWIDTH-1:0] tx_head;
  logic              tx_nempty;
  logic              tx_pop;
  logic              rx_room;
  logic              rx_push;
  logic              issue_ok;
  logic              issue_go;
  logic              abort;

  sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  (bus.tx_data),
    .in_valid_i (bus.tx_valid),
    .in_ready_o (bus.tx_ready),
    .out_data_o (tx_head),
    .out_valid_o(tx_nempty),
    .out_ready_i(tx_pop)
  );

  sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  (bus.core_dout),
    .in_valid_i (rx_push),
    .in_ready_o (rx_room),
    .out_data_o (bus.rx_data),
    .out_valid_o(bus.rx_valid),
    .out_ready_i(bus.rx_ready)
  );

  // Only one word is ever in flight, so checking RX room at issue time
  // guarantees the WAIT_HI push lands when overflow dropping is disabled.
  assign issue_ok = tx_nempty && (OVF_EN || rx_room);
  assign rx_push  = (state_q == S_WAIT_HI) && bus.core_done;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ss_n_d   = ss_n_q;
    wr_d     = 1'b0;
    din_d    = din_q;
    err_d    = err_q;
    tx_pop   = 1'b0;
    issue_go = 1'b0;
    abort    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_nempty) begin
          state_d = S_LEAD;
          ss_n_d  = 1'b0;
          cnt_d   = LEAD_LD;
        end
      end
      S_LEAD: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (issue_ok) issue_go = 1'b1;
      end
      S_ISSUE: begin
        state_d = S_WAIT_LO;
        cnt_d   = TMO_LD;
      end
      S_WAIT_LO: begin
        if (!bus.core_done) begin
          state_d = S_WAIT_HI;
          cnt_d   = TMO_LD;
        end else if (cnt_q == '0) abort = 1'b1;
        else cnt_d = cnt_q - 1'b1;
      end
      S_WAIT_HI: begin
        if (bus.core_done) state_d = S_NEXT;
        else if (cnt_q == '0) abort = 1'b1;
        else cnt_d = cnt_q - 1'b1;
      end
      S_NEXT: begin
        if (tx_nempty) begin
          if (issue_ok) issue_go = 1'b1;
        end else begin
          state_d = S_TAIL;
          cnt_d   = TAIL_LD;
        end
      end
      S_TAIL: begin
        if (issue_ok) issue_go = 1'b1;
        else if (cnt_q == '0) begin
          state_d = S_IDLE;
          ss_n_d  = 1'b1;
        end else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (issue_go) begin
      tx_pop  = 1'b1;
      din_d   = tx_head;
      wr_d    = 1'b1;
      state_d = S_ISSUE;
    end
    if (abort) begin
      err_d   = 1'b1;
      ss_n_d  = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ss_n_q  <= 1'b1;
      wr_q    <= 1'b0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ss_n_q  <= ss_n_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

`ifdef SPI_XFER_RX_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else if (rx_push && !rx_room) ovf_q <= 1'b1;
  end

  assign bus.rx_ovf = ovf_q;
`endif

  assign bus.core_cs  = wr_q;
  assign bus.core_wr  = wr_q;
  assign bus.core_rd  = 1'b0;
  assign bus.core_din = din_q;
  assign bus.ss_n     = ss_n_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.err      = err_q;
endmodule
